pipeline_issue_controller: RTL

//  Sequences the 5-stage IF/ID/EX/MEM/WB datapath. Fetches PC+4 speculatively, redirects from WB on mispredict,

---
 rtl/pipeline_issue_controller_pkg.sv | 29 ++
 rtl/pipeline_issue_controller_reg_scoreboard.sv | 51 +++++
 rtl/pipeline_issue_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_issue_controller_pkg.sv
// Shared types and constants for the 5-stage issue controller and its
// register scoreboard.
package pipeline_issue_controller_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic REG_WRITE_ENABLE = 1'b1;
    localparam logic RAM_WRITE_ENABLE = 1'b1;

    typedef enum logic [0:0] {
        STATE_RUN      = 1'b0,
        STATE_MEM_WAIT = 1'b1
    } issue_state_t;

    // One action is chosen per cycle; order encodes priority (flush highest).
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_STALL   = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } issue_action_t;

    // x0 is hardwired to zero, so it can never carry a pending write.
    function automatic logic is_tracked_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/pipeline_issue_controller_reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register,
// with two source lookups and one destination (WAW) lookup.
module pipeline_issue_controller_reg_scoreboard
    import pipeline_issue_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_address,
    input  logic                  clear_en,
    input  logic [REG_ADDR_W-1:0] clear_address,
    input  logic [REG_ADDR_W-1:0] rs1_address,
    input  logic [REG_ADDR_W-1:0] rs2_address,
    input  logic [REG_ADDR_W-1:0] rd_address,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // Set wins over clear only in theory; the WAW stall keeps them disjoint.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign busy_next[gi] =
                    flush ? 1'b0 :
                    (set_en   && set_address   == REG_ADDR_W'(gi)) ? 1'b1 :
                    (clear_en && clear_address == REG_ADDR_W'(gi)) ? 1'b0 :
                    busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rs1_busy = busy_reg[rs1_address];
    assign rs2_busy = busy_reg[rs2_address];
    assign rd_busy  = busy_reg[rd_address];

endmodule

// File: rtl/pipeline_issue_controller.sv
// Issue/sequencing controller for the IF/ID/EX/MEM/WB datapath: stage valids,
// pipeline-register enables, PC redirect, hazard stalls and multi-cycle MEM.
module pipeline_issue_controller
    import pipeline_issue_controller_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_address,
    input  logic                  id_reg_wren,
    input  logic                  mem_ram_access,
    input  logic                  mem_ram_wren,
    input  logic [REG_ADDR_W-1:0] wb_rd_address,
    input  logic                  wb_reg_wren,
    input  logic                  wb_mispredict,
    output logic                  pc_wren,
    output logic                  pc_redirect,
    output logic                  if_id_wren,
    output logic                  id_ex_wren,
    output logic                  ex_mem_wren,
    output logic                  mem_wb_wren,
    output logic                  id_valid,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic                  ram_wren,
    output logic                  reg_wren,
    output logic [31:0]           stall_count
);

    localparam logic             MULTI_CYCLE_RAM = (RAM_LATENCY > 1);
    localparam logic [CNT_W-1:0] WAIT_RELOAD     = CNT_W'(RAM_LATENCY - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST       = CNT_W'(1);

    issue_state_t  state_reg, state_next;
    issue_action_t action;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [31:0] stall_count_reg;
    logic id_valid_reg, ex_valid_reg, mem_valid_reg, wb_valid_reg;
    logic id_valid_next, ex_valid_next, mem_valid_next, wb_valid_next;

    logic flush;
    logic hazard;
    logic mem_entry;
    logic mem_hold;
    logic last_mem_cycle;
    logic rs1_busy, rs2_busy, rd_busy;
    logic sb_set_en, sb_clear_en;

    assign flush  = wb_valid_reg & wb_mispredict;
    assign hazard = id_valid_reg & ((id_rs1_used & rs1_busy) |
                                    (id_rs2_used & rs2_busy) |
                                    (id_reg_wren & rd_busy));

    // The first MEM cycle of a multi-cycle access is held from RUN; the
    // counter then covers the remaining RAM_LATENCY-1 cycles.
    assign mem_entry = (state_reg == STATE_RUN) & mem_valid_reg & mem_ram_access & MULTI_CYCLE_RAM;
    assign mem_hold  = mem_entry | ((state_reg == STATE_MEM_WAIT) & (wait_cnt_reg != WAIT_LAST));
    assign last_mem_cycle = (state_reg == STATE_MEM_WAIT) ? (wait_cnt_reg == WAIT_LAST) : ~mem_entry;

    always_comb begin
        action = ACT_ADVANCE;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (mem_hold) begin
            action = ACT_HOLD;
        end else if (hazard) begin
            action = ACT_STALL;
        end
    end

    always_comb begin
        pc_wren        = 1'b1;
        pc_redirect    = 1'b0;
        if_id_wren     = 1'b1;
        id_ex_wren     = 1'b1;
        ex_mem_wren    = 1'b1;
        mem_wb_wren    = 1'b1;
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        id_valid_next  = 1'b1;
        ex_valid_next  = id_valid_reg;
        mem_valid_next = ex_valid_reg;
        wb_valid_next  = mem_valid_reg;

        case (action)
            ACT_FLUSH: begin
                pc_redirect    = 1'b1;
                id_valid_next  = 1'b0;
                ex_valid_next  = 1'b0;
                mem_valid_next = 1'b0;
                wb_valid_next  = 1'b0;
                state_next     = STATE_RUN;
                wait_cnt_next  = '0;
            end
            ACT_HOLD: begin
                pc_wren        = 1'b0;
                if_id_wren     = 1'b0;
                id_ex_wren     = 1'b0;
                ex_mem_wren    = 1'b0;
                id_valid_next  = id_valid_reg;
                ex_valid_next  = ex_valid_reg;
                mem_valid_next = mem_valid_reg;
                wb_valid_next  = 1'b0;
                if (mem_entry) begin
                    state_next    = STATE_MEM_WAIT;
                    wait_cnt_next = WAIT_RELOAD;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_LAST;
                end
            end
            ACT_STALL: begin
                pc_wren       = 1'b0;
                if_id_wren    = 1'b0;
                id_valid_next = id_valid_reg;
                ex_valid_next = 1'b0;
            end
            default: begin
            end
        endcase

        // Final MEM_WAIT cycle: the access completes whether or not ID stalls.
        if (action != ACT_FLUSH && action != ACT_HOLD && state_reg == STATE_MEM_WAIT) begin
            state_next    = STATE_RUN;
            wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= STATE_RUN;
            wait_cnt_reg    <= '0;
            id_valid_reg    <= 1'b0;
            ex_valid_reg    <= 1'b0;
            mem_valid_reg   <= 1'b0;
            wb_valid_reg    <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            id_valid_reg    <= id_valid_next;
            ex_valid_reg    <= ex_valid_next;
            mem_valid_reg   <= mem_valid_next;
            wb_valid_reg    <= wb_valid_next;
            if (!pc_wren) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign sb_set_en   = (action == ACT_ADVANCE) & id_valid_reg &
                         (id_reg_wren == REG_WRITE_ENABLE) & is_tracked_reg(id_rd_address);
    assign sb_clear_en = wb_valid_reg & (wb_reg_wren == REG_WRITE_ENABLE) & mem_wb_wren;

    pipeline_issue_controller_reg_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .set_en        (sb_set_en),
        .set_address   (id_rd_address),
        .clear_en      (sb_clear_en),
        .clear_address (wb_rd_address),
        .rs1_address   (id_rs1_address),
        .rs2_address   (id_rs2_address),
        .rd_address    (id_rd_address),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rd_busy       (rd_busy)
    );

    assign id_valid    = id_valid_reg;
    assign ex_valid    = ex_valid_reg;
    assign mem_valid   = mem_valid_reg;
    assign wb_valid    = wb_valid_reg;
    assign reg_wren    = wb_valid_reg & (wb_reg_wren == REG_WRITE_ENABLE);
    assign ram_wren    = mem_valid_reg & (mem_ram_wren == RAM_WRITE_ENABLE) & last_mem_cycle & ~flush;
    assign stall_count = stall_count_reg;

endmodule
